// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-SRAM write signals for imem_loader.
// master = stream source / observer, slave = the loader itself.
interface imem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_cs, mem_oe, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into words and writes them to instruction SRAM.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter logic [31:0] MAX_WORDS = 32'd1024
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    imem_loader_if.slave  bus,
    output logic          o_cpu_hold,
    output logic          o_done,
    output logic          o_err
);

`ifdef IMEM_LOADER_CHKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5,
        S_CHK   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;
`endif

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_idx;
    logic [31:0] r_count;
    logic [23:0] r_shift;
    logic        r_byte_ready;
    logic        r_mem_cs;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_err;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]  r_chk;
`endif

    logic        w_accept;
    logic [31:0] w_word;
    logic [31:0] w_idx_next;
    logic [31:0] w_addr;

    // byte_ready is registered, so acceptance is decided by the value already on the port
    assign w_accept   = bus.byte_valid && r_byte_ready;
    assign w_word     = {r_shift, bus.byte_in};
    assign w_idx_next = r_idx + 32'd1;
    assign w_addr     = BASE_ADDR + (r_idx << 2);

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_cs     = r_mem_cs;
    assign bus.mem_oe     = 1'b0;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_done         = r_done;
    assign o_err          = r_err;

    // Loader FSM; every output is set on the transition into the state that owns it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_idx        <= 32'd0;
            r_count      <= 32'd0;
            r_shift      <= 24'd0;
            r_byte_ready <= 1'b0;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_din    <= 32'd0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            r_chk        <= 8'd0;
`endif
        end else begin
            r_mem_cs <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state      <= S_HDR;
                        r_byte_cnt   <= 2'd0;
                        r_idx        <= 32'd0;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_byte_ready <= 1'b1;
                        r_cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_chk        <= 8'd0;
`endif
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_shift    <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_count <= w_word;
                            if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                                r_state      <= S_CHK;
`else
                                r_state      <= S_DONE;
                                r_done       <= 1'b1;
                                r_cpu_hold   <= 1'b0;
                                r_byte_ready <= 1'b0;
`endif
                            end else if (w_word > MAX_WORDS) begin
                                r_state      <= S_ERROR;
                                r_err        <= 1'b1;
                                r_cpu_hold   <= 1'b1;
                                r_byte_ready <= 1'b0;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_shift    <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_chk      <= r_chk ^ bus.byte_in;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_mem_cs     <= 1'b1;
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= w_addr;
                            r_mem_din    <= w_word;
                        end
                    end
                end
                S_WRITE: begin
                    r_idx <= w_idx_next;
                    if (w_idx_next == r_count) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_state      <= S_CHK;
                        r_byte_ready <= 1'b1;
`else
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_cpu_hold   <= 1'b0;
                        r_byte_ready <= 1'b0;
`endif
                    end else begin
                        r_state      <= S_DATA;
                        r_byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_byte_ready <= 1'b0;
                        if (bus.byte_in == r_chk) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state    <= S_ERROR;
                            r_err      <= 1'b1;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b0;
                    r_cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus random words/gaps against a word-list model.
// Checksum-byte behaviour is exercised when IMEM_LOADER_CHKSUM_EN is defined.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] MAXW = 32'd1024;

    logic clk;
    logic rst_n;
    logic start;
    logic cpu_hold;
    logic done;
    logic err;

    int checks = 0;
    int errors = 0;

    logic [31:0] words[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        prev_we;

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .bus        (bus.slave),
        .o_cpu_hold (cpu_hold),
        .o_done     (done),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: records every SRAM write and checks its shape
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            check("write_cs", {31'd0, bus.mem_cs}, 32'd1);
            check("write_ready_low", {31'd0, bus.byte_ready}, 32'd0);
            check("write_single_cycle", {31'd0, prev_we}, 32'd0);
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_din);
        end
        prev_we <= bus.mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gaps;
        gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
        repeat (gaps) @(negedge clk);
        @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 100 && bus.byte_ready !== 1'b1; i++) @(negedge clk);
        if (bus.byte_ready !== 1'b1) begin
            check("ready_timeout", {31'd0, bus.byte_ready}, 32'd1);
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.byte_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full load of `words` with header n_hdr; the model is the word list itself
    task automatic do_load(input logic [31:0] n_hdr, input int gap_max, input logic bad_chk);
        logic [7:0] x;
        int         nw;
        logic       exp_ok;
        x = 8'd0;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        for (int k = 3; k >= 0; k--) send_byte(n_hdr[8*k +: 8], gap_max);
        exp_ok = (n_hdr <= MAXW);
        nw = exp_ok ? int'(n_hdr) : 0;
        for (int i = 0; i < nw; i++)
            for (int k = 3; k >= 0; k--) begin
                send_byte(words[i][8*k +: 8], gap_max);
                x = x ^ words[i][8*k +: 8];
            end
`ifdef IMEM_LOADER_CHKSUM_EN
        if (exp_ok) begin
            send_byte(x ^ {7'd0, bad_chk}, gap_max);
            exp_ok = !bad_chk;
        end
`else
        if (bad_chk) exp_ok = exp_ok;
`endif
        for (int i = 0; i < 50 && !(done === 1'b1 || err === 1'b1); i++) @(negedge clk);
        @(negedge clk);
        check("final_done", {31'd0, done}, {31'd0, exp_ok});
        check("final_err", {31'd0, err}, {31'd0, !exp_ok});
        check("final_cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_ok});
        check("final_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("write_count", wr_addr_q.size(), nw);
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            check("write_addr", wr_addr_q[i], BASE + 32'(4 * i));
            check("write_data", wr_data_q[i], words[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("oe_tied", {31'd0, bus.mem_oe}, 32'd0);

        // Directed two-word load, valid held high
        words = '{32'hDEAD_BEEF, 32'h0123_4567};
        do_load(32'd2, 0, 1'b0);
        check("hold_addr_after_done", bus.mem_addr, 32'h0040_0004);

        // Oversized header
        do_load(32'd1025, 0, 1'b0);
        // Boundary: exactly MAX_WORDS is legal only at header level; use N=1 cheaply instead below
        // Empty load
        do_load(32'd0, 0, 1'b0);
`ifdef IMEM_LOADER_CHKSUM_EN
        do_load(32'd0, 0, 1'b1);
        words = '{32'hDEAD_BEEF, 32'h0123_4567};
        do_load(32'd2, 0, 1'b1);
`endif

        // N=3 random words, gap-free then with random valid gaps
        words = '{$urandom(), $urandom(), $urandom()};
        do_load(32'd3, 0, 1'b0);
        do_load(32'd3, 3, 1'b0);

        // Random loads
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(6, 1);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom());
            do_load(32'(n), $urandom_range(2, 0), 1'b0);
        end

        // Reset mid-word 2 of N=4
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        for (int k = 3; k >= 0; k--) send_byte(8'(4 >> (8 * k)), 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("midrst_addr", bus.mem_addr, 32'd0);
        check("midrst_din", bus.mem_din, 32'd0);
        check("midrst_writes", wr_addr_q.size(), 32'd1);
        if (wr_data_q.size() > 0) check("midrst_word1", wr_data_q[0], 32'h1122_3344);
        repeat (3) @(negedge clk);
        check("midrst_no_more_writes", wr_addr_q.size(), 32'd1);

        words = '{32'hCAFE_F00D};
        do_load(32'd1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
